// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment reader: active-low segment patterns
// (bit6=g .. bit0=a), special nibble codes and the frame FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] ERR_CODE   = 4'hE;

  typedef enum logic {
    COLLECT,
    PEND
  } state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational lookup from an active-low segment pattern back to a BCD nibble.
// Blank maps to BLANK_CODE without error; anything unrecognised flags an error.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] bcd_o,
  output logic       err_o
);

  always_comb begin
    bcd_o = ERR_CODE;
    err_o = 1'b0;
    case (seg_i)
      SEG_0:     bcd_o = 4'd0;
      SEG_1:     bcd_o = 4'd1;
      SEG_2:     bcd_o = 4'd2;
      SEG_3:     bcd_o = 4'd3;
      SEG_4:     bcd_o = 4'd4;
      SEG_5:     bcd_o = 4'd5;
      SEG_6:     bcd_o = 4'd6;
      SEG_7:     bcd_o = 4'd7;
      SEG_8:     bcd_o = 4'd8;
      SEG_9:     bcd_o = 4'd9;
      SEG_BLANK: bcd_o = BLANK_CODE;
      default: begin
        bcd_o = ERR_CODE;
        err_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Stability-filtered reader of a multiplexed seven-segment stream that delivers
// whole BCD frames over valid/ready. Define SEG7_READER_DP_EN to add the dp bit.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [6:0]                  in_seg,
  input  logic [$clog2(DIGITS)-1:0]   in_digit,
`ifdef SEG7_READER_DP_EN
  input  logic                        in_dp,
  output logic [DIGITS-1:0]           out_dp,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [4*DIGITS-1:0]         out_bcd,
  output logic [DIGITS-1:0]           out_err_mask,
  output logic                        out_err,
  output logic                        out_overrun
);

  localparam int DW = $clog2(DIGITS);
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] SAT = CW'(STABLE_CNT);
  localparam logic [DW:0] DIGITS_W = (DW + 1)'(DIGITS);

`ifdef SEG7_READER_DP_EN
  localparam int PW = 8;
  logic [PW-1:0] sample;
  assign sample = {in_dp, in_seg};
`else
  localparam int PW = 7;
  logic [PW-1:0] sample;
  assign sample = in_seg;
`endif

  state_e              state_q, state_d;
  logic [PW-1:0]       lastPat_q [DIGITS];
  logic [PW-1:0]       lastPat_d [DIGITS];
  logic [CW-1:0]       cnt_q [DIGITS];
  logic [CW-1:0]       cnt_d [DIGITS];
  logic [3:0]          stgBcd_q [DIGITS];
  logic [3:0]          stgBcd_d [DIGITS];
  logic [DIGITS-1:0]   stgErr_q, stgErr_d;
  logic [DIGITS-1:0]   captured_q, captured_d, capMask;
  logic                outValid_q, overrun_q;
  logic [4*DIGITS-1:0] outBcd_q, loadBcd;
  logic [DIGITS-1:0]   outErr_q;
  logic [3:0]          decBcd;
  logic                decErr;
  logic                inRange, accept, slotFree, frameDone;
  logic                load, park, dropFrame, clearFrame;

  seg7_to_bcd u_dec (
    .seg_i (in_seg),
    .bcd_o (decBcd),
    .err_o (decErr)
  );

  // A sample on the cycle a pending frame is handed over is discarded outright.
  assign inRange  = {1'b0, in_digit} < DIGITS_W;
  assign slotFree = !outValid_q || out_ready;
  assign accept   = in_valid && inRange && !(state_q == PEND && slotFree);

  always_comb begin
    capMask = '0;
    for (int d = 0; d < DIGITS; d++) begin
      lastPat_d[d] = lastPat_q[d];
      cnt_d[d]     = cnt_q[d];
      if (accept && in_digit == DW'(d)) begin
        if (sample == lastPat_q[d]) begin
          if (cnt_q[d] != SAT) cnt_d[d] = cnt_q[d] + 1'b1;
        end else begin
          lastPat_d[d] = sample;
          cnt_d[d]     = CW'(1);
        end
        if (STABLE_CNT == 1 || (cnt_d[d] == SAT && cnt_q[d] != SAT)) capMask[d] = 1'b1;
      end
    end
  end

  assign frameDone = &(captured_q | capMask);

  always_ff @(posedge clk) begin
    if (reset) state_q <= COLLECT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (frameDone && !slotFree) state_d = PEND;
      PEND:    if (slotFree) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    load      = 1'b0;
    park      = 1'b0;
    dropFrame = 1'b0;
    case (state_q)
      COLLECT: begin
        load = frameDone && slotFree;
        park = frameDone && !slotFree;
      end
      PEND: begin
        load      = slotFree;
        dropFrame = !slotFree && frameDone;
      end
      default: ;
    endcase
  end

  assign clearFrame = load || park || dropFrame;

  // Staging only accepts captures while collecting; it is frozen behind a pending frame.
  always_comb begin
    captured_d = captured_q | capMask;
    stgErr_d   = stgErr_q;
    loadBcd    = '0;
    for (int d = 0; d < DIGITS; d++) begin
      stgBcd_d[d] = stgBcd_q[d];
      if (state_q == COLLECT && capMask[d]) begin
        stgBcd_d[d] = decBcd;
        stgErr_d[d] = decErr;
      end
      loadBcd[4*d +: 4] = stgBcd_d[d];
    end
    if (clearFrame) captured_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int d = 0; d < DIGITS; d++) begin
        lastPat_q[d] <= '1;
        cnt_q[d]     <= '0;
        stgBcd_q[d]  <= '0;
      end
      stgErr_q   <= '0;
      captured_q <= '0;
      outValid_q <= 1'b0;
      outBcd_q   <= '0;
      outErr_q   <= '0;
      overrun_q  <= 1'b0;
    end else begin
      for (int d = 0; d < DIGITS; d++) begin
        lastPat_q[d] <= lastPat_d[d];
        cnt_q[d]     <= clearFrame ? '0 : cnt_d[d];
        stgBcd_q[d]  <= stgBcd_d[d];
      end
      stgErr_q   <= stgErr_d;
      captured_q <= captured_d;
      overrun_q  <= dropFrame;
      if (load) begin
        outValid_q <= 1'b1;
        outBcd_q   <= loadBcd;
        outErr_q   <= stgErr_d;
      end else if (out_ready) begin
        outValid_q <= 1'b0;
      end
    end
  end

`ifdef SEG7_READER_DP_EN
  logic [DIGITS-1:0] stgDp_q, stgDp_d, outDp_q;

  always_comb begin
    stgDp_d = stgDp_q;
    for (int d = 0; d < DIGITS; d++)
      if (state_q == COLLECT && capMask[d]) stgDp_d[d] = ~in_dp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stgDp_q <= '0;
      outDp_q <= '0;
    end else begin
      stgDp_q <= stgDp_d;
      if (load) outDp_q <= stgDp_d;
    end
  end

  assign out_dp = outDp_q;
`endif

  assign out_valid    = outValid_q;
  assign out_bcd      = outBcd_q;
  assign out_err_mask = outErr_q;
  assign out_err      = |outErr_q;
  assign out_overrun  = overrun_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader (DIGITS=4, STABLE_CNT=3): a vector table of
// complete frames plus hand-written glitch, overrun and mid-frame reset sequences.
module tb_seg7_reader;

  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P6 = 7'b0000010;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0011000;
  localparam logic [6:0] PB = 7'b1111111;
  localparam logic [6:0] PX = 7'b1010101;

  typedef struct packed {
    logic [27:0] pats;
    logic [15:0] expBcd;
    logic [3:0]  expMask;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready;
  logic [6:0]  in_seg;
  logic [1:0]  in_digit;
  logic        out_valid, out_err, out_overrun;
  logic [15:0] out_bcd;
  logic [3:0]  out_err_mask;
`ifdef SEG7_READER_DP_EN
  logic        in_dp = 1'b1;
  logic [3:0]  out_dp;
`endif

  int          checks = 0;
  int          failures = 0;
  int          validSeen, overrunSeen;
  logic [15:0] seenBcd;
  logic [3:0]  seenMask;
  logic        seenErr;
  vec_t        vecs [4];

  always #5 clk = ~clk;

  seg7_reader #(.DIGITS(4), .STABLE_CNT(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_seg       (in_seg),
    .in_digit     (in_digit),
`ifdef SEG7_READER_DP_EN
    .in_dp        (in_dp),
    .out_dp       (out_dp),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bcd      (out_bcd),
    .out_err_mask (out_err_mask),
    .out_err      (out_err),
    .out_overrun  (out_overrun)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic clearMon();
    validSeen   = 0;
    overrunSeen = 0;
    seenBcd     = 'x;
    seenMask    = 'x;
    seenErr     = 1'bx;
  endtask

  // Outputs are observed on the falling edge, halfway between active edges.
  task automatic tick();
    @(negedge clk);
    if (out_valid === 1'b1) begin
      validSeen++;
      seenBcd  = out_bcd;
      seenMask = out_err_mask;
      seenErr  = out_err;
    end
    if (out_overrun === 1'b1) overrunSeen++;
  endtask

  task automatic applyStimulus(input int d, input logic [6:0] seg);
    tick();
    in_valid = 1'b1;
    in_digit = 2'(d);
    in_seg   = seg;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic feedFrame(input logic [27:0] pats);
    for (int r = 0; r < 3; r++)
      for (int d = 0; d < 4; d++)
        applyStimulus(d, pats[7*d +: 7]);
    idle(2);
  endtask

  initial begin
    vecs[0] = '{pats: {P4, P3, P2, P1}, expBcd: 16'h4321, expMask: 4'b0000};
    vecs[1] = '{pats: {PB, P7, PX, P5}, expBcd: 16'hF7E5, expMask: 4'b0010};
    vecs[2] = '{pats: {P6, P8, P9, P0}, expBcd: 16'h6890, expMask: 4'b0000};
    vecs[3] = '{pats: {PB, PB, PB, PB}, expBcd: 16'hFFFF, expMask: 4'b0000};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_seg    = PB;
    in_digit  = 2'd0;
    out_ready = 1'b1;
    clearMon();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    idle(4);
    checkOutput("reset_valid_never", validSeen, 0);
    checkOutput("reset_bcd", out_bcd, 16'h0000);
    checkOutput("reset_mask", out_err_mask, 4'b0000);
    checkOutput("reset_err", out_err, 1'b0);
    checkOutput("reset_overrun", out_overrun, 1'b0);

    for (int i = 0; i < 4; i++) begin
      clearMon();
      feedFrame(vecs[i].pats);
      checkOutput($sformatf("vec%0d_valid_pulses", i), validSeen, 1);
      checkOutput($sformatf("vec%0d_bcd", i), seenBcd, vecs[i].expBcd);
      checkOutput($sformatf("vec%0d_mask", i), seenMask, vecs[i].expMask);
      checkOutput($sformatf("vec%0d_err", i), seenErr, |vecs[i].expMask);
    end

    // Digit 2 glitches to a 6 mid-run; only the final stable run may capture.
    clearMon();
    for (int r = 0; r < 3; r++) begin
      applyStimulus(0, P0);
      applyStimulus(1, P1);
      applyStimulus(3, P3);
    end
    applyStimulus(2, P2);
    applyStimulus(2, P2);
    applyStimulus(2, P6);
    applyStimulus(2, P2);
    applyStimulus(2, P2);
    applyStimulus(2, P2);
    checkOutput("glitch_no_early_valid", validSeen, 0);
    idle(2);
    checkOutput("glitch_valid_pulses", validSeen, 1);
    checkOutput("glitch_bcd", seenBcd, 16'h3210);

    // Consumer stalls across three frames: hold, pend, then overrun.
    out_ready = 1'b0;
    clearMon();
    feedFrame({P4, P3, P2, P1});
    checkOutput("stall_a_valid", out_valid, 1'b1);
    checkOutput("stall_a_bcd", out_bcd, 16'h4321);
    clearMon();
    feedFrame({P8, P7, P6, P5});
    checkOutput("stall_b_hold_bcd", out_bcd, 16'h4321);
    checkOutput("stall_b_no_overrun", overrunSeen, 0);
    clearMon();
    feedFrame({P2, P1, P0, P9});
    checkOutput("stall_c_overrun", overrunSeen, 1);
    checkOutput("stall_c_hold_bcd", out_bcd, 16'h4321);
    checkOutput("stall_c_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    tick();
    checkOutput("release_b2b_valid", out_valid, 1'b1);
    checkOutput("release_b2b_bcd", out_bcd, 16'h8765);
    checkOutput("release_overrun_low", out_overrun, 1'b0);
    tick();
    checkOutput("release_drain_valid", out_valid, 1'b0);

    // Reset after two digits are captured discards the partial frame.
    clearMon();
    for (int r = 0; r < 3; r++) begin
      applyStimulus(0, P7);
      applyStimulus(1, P8);
    end
    tick();
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    for (int r = 0; r < 3; r++) begin
      applyStimulus(2, P9);
      applyStimulus(3, P0);
    end
    idle(2);
    checkOutput("rst_partial_no_frame", validSeen, 0);
    for (int r = 0; r < 2; r++) begin
      applyStimulus(0, P7);
      applyStimulus(1, P8);
    end
    idle(2);
    checkOutput("rst_cnt_restart", validSeen, 0);
    applyStimulus(0, P7);
    applyStimulus(1, P8);
    idle(2);
    checkOutput("rst_frame_valid", validSeen, 1);
    checkOutput("rst_frame_bcd", seenBcd, 16'h0987);
    checkOutput("rst_no_overrun", overrunSeen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_reader.md
# seg7_reader

Inverse of the BCD-to-seven-segment path. It samples a time-multiplexed stream of active-low segment patterns, one digit position per sample, and filters each position for stability. Each stable pattern is converted back to a 4-bit BCD nibble, and a complete multi-digit frame is delivered over a valid/ready handshake. It sits between a scanned-display capture front end (or a loopback of our own display drive) and consumers that need the numeric value.

## Interface
- DIGITS, 4, digit positions per frame (≥2)
- STABLE_CNT, 3, consecutive identical samples required to accept a digit (≥1)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clears all state
- in_valid  in  1  sample strobe
- in_seg  in  7  active-low segments, bit6=g … bit0=a
- in_digit  in  $clog2(DIGITS)  position of sample; values ≥ DIGITS ignored
- out_valid  out  1  frame available
- out_ready  in  1  consumer accepts frame
- out_bcd  out  4*DIGITS  nibble i = digit i
- out_err_mask  out  DIGITS  bit i set = digit i undecodable
- out_err  out  1  OR of out_err_mask
- out_overrun  out  1  one-cycle pulse: completed frame dropped

## Operation
- Decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000 → nibble 0–9.
- 1111111 (blank) → 4'hF, no error; any other pattern → 4'hE, error bit set.
- Per position d: last_pat[d], cnt[d] saturating at STABLE_CNT. On accepted sample:
  - in_seg == last_pat[d] → cnt[d]+1.
  - Otherwise → last_pat[d]=in_seg, cnt[d]=1.
- Capture: when cnt[d] becomes STABLE_CNT, write the decoded nibble and error bit into staging[d] and set captured[d]. Saturated re-hits do not re-capture.
- States:
  - COLLECT → frame complete (captured all-ones, including this cycle's capture) with slot free (out_valid=0 or out_ready=1): load output, clear captured, clear all cnt; stay COLLECT.
  - COLLECT → frame complete with slot busy: PEND.
  - PEND: filters keep updating (last_pat, cnt). Staging is frozen; captures are dropped and each dropped capture of a completed frame pulses out_overrun. When the slot frees, load from staging → COLLECT.
- A sample arriving on a load cycle is discarded (counters cleared take priority).
- out_bcd / out_err_mask hold stable while out_valid && !out_ready.

## Timing
- Reset values:
  - Outputs: out_valid=0, out_bcd=0, out_err_mask=0, out_err=0, out_overrun=0.
  - Internal: last_pat=7'h7F, cnt=0, captured=0, state COLLECT.
- Latency: the capture completing a frame at edge k with slot free → out_valid=1 after edge k. Registered, no combinational in→out paths.
- Handshake: transfer on edge with out_valid && out_ready. Back-to-back frames are allowed: a load on the same edge as a transfer keeps out_valid=1.
- STABLE_CNT=1: every in-range sample captures.
- Reset asserted mid-frame or in PEND: everything cleared next edge, pending frame lost, no overrun pulse.

## Configuration
- SEG7_READER_DP_EN defined:
  - Adds in_dp (1 bit, active-low) and out_dp (DIGITS bits, active-high).
  - The dp bit participates in the stability compare.
  - out_dp is registered alongside out_bcd.
- Undefined: ports absent; behaviour otherwise identical.

## Structure
- Package seg7_pkg:
  - Pattern constants SEG_0…SEG_9, SEG_BLANK.
  - Nibble codes BLANK_CODE=4'hF, ERR_CODE=4'hE.
  - State enum {COLLECT, PEND}.
- Sub-module seg7_to_bcd: combinational pattern→{nibble, err} lookup, instantiated once on in_seg.

## Test plan
- Reset held 2 cycles, then released with no input → all outputs 0, out_valid stays 0.
- DIGITS=4, STABLE_CNT=3, out_ready=1; digits 0..3 fed patterns for 1,2,3,4, each scanned 3 times → single out_valid pulse, out_bcd=16'h4321, out_err=0.
- Digit 2 sequence 0100100, 0100100, 0000010, 0100100, 0100100, 0100100 → capture only on final sample, nibble 2; the glitch value 6 never appears.
- Digit 1 gets 1010101, digit 3 gets 1111111, others valid → nibbles E and F, out_err_mask=4'b0010, out_err=1.
- out_ready=0 through three complete frames → frame 1 held stable, frame 2 pending, frame 3 completion pulses out_overrun. Raise out_ready → frame 1 transfers and frame 2 is presented on the same edge.
- Reset pulsed after 2 of 4 digits captured → next frame requires all 4 digits recaptured from cnt=0.
